// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one uart_tx between two NBYTES-wide block requesters.
// Optional UART_ARB_HEADER_EN prefixes each block with header byte 8'hA0 | grant_id.
module uart_tx_arbiter #(
  parameter int NBYTES   = 16,
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [8*NBYTES-1:0]   req0_data,
  output logic                  req0_ack,
  input  logic                  req1_valid,
  input  logic [8*NBYTES-1:0]   req1_data,
  output logic                  req1_ack,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_busy,
  output logic                  active,
  output logic                  grant_id
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;
`ifdef UART_ARB_HEADER_EN
  localparam int         SW   = 8*NBYTES + 8;
  localparam logic [7:0] LAST = 8'(NBYTES);
`else
  localparam int         SW   = 8*NBYTES;
  localparam logic [7:0] LAST = 8'(NBYTES - 1);
`endif
  if (NBYTES < 1 || NBYTES > 255 || CLK_FREQ < 1) begin : g_cfg_err
    $error("uart_tx_arbiter: NBYTES must be 1..255 and CLK_FREQ positive");
  end
  logic [1:0]          state;
  logic [7:0]          cnt;
  logic [SW-1:0]       sh;
  logic                last_grant;
  logic                pick1;
  logic [8*NBYTES-1:0] win_data;
  logic [SW-1:0]       load;
  // On a tie the requester that was not served last wins.
  assign pick1    = req1_valid & (~req0_valid | ~last_grant);
  assign win_data = pick1 ? req1_data : req0_data;
`ifdef UART_ARB_HEADER_EN
  assign load = {win_data, 7'h50, pick1};
`else
  assign load = win_data;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      sh         <= '0;
      last_grant <= 1'b1;
      req0_ack   <= 1'b0;
      req1_ack   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      active     <= 1'b0;
      grant_id   <= 1'b0;
    end else begin
      req0_ack <= 1'b0;
      req1_ack <= 1'b0;
      tx_valid <= 1'b0;
      case (state)
        IDLE: if (req0_valid | req1_valid) begin
          sh         <= load;
          req0_ack   <= ~pick1;
          req1_ack   <= pick1;
          grant_id   <= pick1;
          last_grant <= pick1;
          active     <= 1'b1;
          cnt        <= '0;
          state      <= ISSUE;
        end
        ISSUE: begin
          tx_data  <= sh[7:0];
          tx_valid <= 1'b1;
          state    <= WAIT_HI;
        end
        WAIT_HI: if (tx_busy) state <= WAIT_LO;
        WAIT_LO: if (!tx_busy) begin
          sh     <= sh >> 8;
          cnt    <= cnt + 8'd1;
          state  <= (cnt == LAST) ? IDLE : ISSUE;
          active <= (cnt != LAST);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
  localparam int NB    = 4;
  localparam int FRAME = 10;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [8*NB-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ack, req1_ack, tx_valid, tx_busy, active, grant_id;
  logic [7:0]    tx_data;
  int            tests = 0, fails = 0;
  logic [7:0]    exp_q[$];
  logic          gnt_q[$];
  int            bcnt, cyc = 0, last_tx = -1000;
  logic          prev_ack0 = 1'b0, prev_ack1 = 1'b0, prev_txv = 1'b0;

  uart_tx_arbiter #(.NBYTES(NB), .CLK_FREQ(100_000_000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ack(req0_ack),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ack(req1_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .active(active), .grant_id(grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // uart_tx stand-in: busy for FRAME cycles after accepting a start pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) bcnt <= 0;
    else if (tx_valid && bcnt == 0) bcnt <= FRAME;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  assign tx_busy = (bcnt != 0);

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_block(logic id, logic [8*NB-1:0] d);
`ifdef UART_ARB_HEADER_EN
    exp_q.push_back(8'hA0 | {7'd0, id});
`endif
    for (int i = 0; i < NB; i++) exp_q.push_back(d[8*i +: 8]);
    gnt_q.push_back(id);
  endtask

  task automatic wait_acks(int n);
    int seen = 0;
    for (int i = 0; i < 5000 && seen < n; i++) begin
      @(negedge clk);
      if (req0_ack | req1_ack) seen++;
    end
    check("ack_timeout", seen, n);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 5000 && (active || tx_busy); i++) @(negedge clk);
    check("idle_timeout", {active, tx_busy}, 0);
  endtask

  task automatic wait_tx(int n);
    int seen = 0;
    for (int i = 0; i < 5000 && seen < n; i++) begin
      @(negedge clk);
      if (tx_valid) seen++;
    end
    check("tx_timeout", seen, n);
  endtask

  // Output monitor: pops the scoreboard on every start pulse and every ack
  always @(negedge clk) begin
    if (tx_valid) begin
      check("tx_while_busy", tx_busy, 0);
      check("tx_gap_ok", (cyc - last_tx) >= FRAME + 3, 1);
      check("tx_pulse_1cyc", prev_txv, 0);
      last_tx = cyc;
      check("tx_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
    end
    if (req0_ack | req1_ack) begin
      check("ack_onehot", req0_ack & req1_ack, 0);
      check("ack_pulse_1cyc", (req0_ack & prev_ack0) | (req1_ack & prev_ack1), 0);
      check("ack_matches_id", req1_ack, grant_id);
      check("grant_expected", gnt_q.size() != 0, 1);
      if (gnt_q.size() != 0) check("grant_id", grant_id, gnt_q.pop_front());
    end
    prev_ack0 = req0_ack;
    prev_ack1 = req1_ack;
    prev_txv  = tx_valid;
  end

  initial begin
    logic [7:0] first_byte;
`ifdef UART_ARB_HEADER_EN
    first_byte = 8'hA0;
`else
    first_byte = 8'h11;
`endif
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ack0", req0_ack, 0);
    check("rst_ack1", req1_ack, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_active", active, 0);
    check("rst_grant_id", grant_id, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single block from req0, latency, and data changed right after ack
    push_block(1'b0, 32'h44332211);
    req0_data  = 32'h44332211;
    req0_valid = 1'b1;
    wait_acks(1);
    check("t1_active_on_ack", active, 1);
    check("t1_issue_no_valid", tx_valid, 0);
    req0_valid = 1'b0;
    req0_data  = 32'hDEADBEEF;
    @(negedge clk);
    check("t1_first_valid", tx_valid, 1);
    check("t1_first_byte", tx_data, first_byte);
    wait_idle();
    check("t1_grant_id", grant_id, 0);
    check("t1_bytes_done", exp_q.size(), 0);

    // Both requesting from reset: alternate 0,1,0,1
    rst = 1'b1;
    req0_data  = 32'h0A0B0CAA;
    req1_data  = 32'h1A1B1CBB;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) push_block(k[0], k[0] ? 32'h1A1B1CBB : 32'h0A0B0CAA);
    @(negedge clk);
    rst = 1'b0;
    wait_acks(4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    check("t2_grant_last", grant_id, 1);
    check("t2_bytes_done", exp_q.size(), 0);
    check("t2_grants_done", gnt_q.size(), 0);

    // Only req1 requesting: served every time
    req1_data  = 32'h87654321;
    req1_valid = 1'b1;
    for (int k = 0; k < 3; k++) push_block(1'b1, 32'h87654321);
    wait_acks(3);
    req1_valid = 1'b0;
    wait_idle();
    check("t3_bytes_done", exp_q.size(), 0);
    check("t3_grants_done", gnt_q.size(), 0);

    // Reset after the second frame starts; rest of block dropped
`ifdef UART_ARB_HEADER_EN
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'h88);
`else
    exp_q.push_back(8'h88);
    exp_q.push_back(8'h77);
`endif
    gnt_q.push_back(1'b0);
    req0_data  = 32'h55667788;
    req0_valid = 1'b1;
    wait_acks(1);
    req0_valid = 1'b0;
    wait_tx(2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t4_rst_tx_valid", tx_valid, 0);
    check("t4_rst_active", active, 0);
    check("t4_rst_grant", grant_id, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4 * FRAME) @(negedge clk);
    check("t4_no_leftover", exp_q.size(), 0);
    check("t4_still_idle", active, 0);
    push_block(1'b0, 32'hCAFEF00D);
    req0_data  = 32'hCAFEF00D;
    req0_valid = 1'b1;
    wait_acks(1);
    req0_valid = 1'b0;
    wait_idle();
    check("t4_fresh_done", exp_q.size(), 0);
    check("t4_grants_done", gnt_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
